// File: rtl/kong_pkg.sv
// rtl/kong_pkg.sv - shared Kong sprite types and constants (controller and renderer)
package kong_pkg;

  typedef enum logic {
    KONG_INITIAL = 1'b0,
    KONG_PLAYING = 1'b1
  } kong_state_t;

  typedef enum logic [1:0] {
    KONG_NORMAL = 2'b00,
    KONG_GET    = 2'b01,
    KONG_HOLD   = 2'b10,
    KONG_DROP   = 2'b11
  } kong_anim_t;

  localparam int KONG_WIDTH  = 112;
  localparam int KONG_HEIGHT = 72;
  localparam int KONG_CNT_W  = 16;

  function automatic kong_anim_t kong_next_anim(input kong_anim_t a);
    case (a)
      KONG_NORMAL: return KONG_GET;
      KONG_GET:    return KONG_HOLD;
      KONG_HOLD:   return KONG_DROP;
      default:     return KONG_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/kong_patrol.sv
// rtl/kong_patrol.sv - horizontal patrol position with clamp-and-bounce at the bounds
module kong_patrol #(
  parameter int X_MIN  = 100,
  parameter int X_MAX  = 540,
  parameter int X_STEP = 2,
  parameter int HOME_X = 320
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [9:0] pos_x
);

  logic        dir_left;
  logic [10:0] pos_wide;
  logic [10:0] right_sum;

  // 11-bit arithmetic so a step past either bound never wraps
  assign pos_wide  = {1'b0, pos_x};
  assign right_sum = pos_wide + 11'(X_STEP);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pos_x    <= 10'(HOME_X);
      dir_left <= 1'b0;
    end else if (en) begin
      if (!dir_left) begin
        if (right_sum >= 11'(X_MAX)) begin
          pos_x    <= 10'(X_MAX);
          dir_left <= 1'b1;
        end else begin
          pos_x <= right_sum[9:0];
        end
      end else begin
        if (pos_wide <= 11'(X_MIN + X_STEP)) begin
          pos_x    <= 10'(X_MIN);
          dir_left <= 1'b0;
        end else begin
          pos_x <= pos_x - 10'(X_STEP);
        end
      end
    end
  end

endmodule

// File: rtl/kong_ctrl.sv
// rtl/kong_ctrl.sv - Kong throw-cycle sequencer, patrol driver and barrel-spawn requester
module kong_ctrl
  import kong_pkg::*;
#(
  parameter int NORMAL_FRAMES = 90,
  parameter int GET_FRAMES    = 20,
  parameter int HOLD_FRAMES   = 30,
  parameter int DROP_FRAMES   = 10,
  parameter int X_MIN         = 100,
  parameter int X_MAX         = 540,
  parameter int X_STEP        = 2,
  parameter int HOME_X        = 320,
  parameter int HOME_Y        = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       game_over,
  input  logic       spawn_ready,
  output logic       state,
  output logic [1:0] animation_state,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic       spawn_valid,
  output logic [9:0] spawn_x,
  output logic [8:0] spawn_y
);

  kong_state_t           state_q, state_n;
  kong_anim_t            anim_q, anim_n;
  logic [KONG_CNT_W-1:0] cnt_q, cnt_n;
  logic                  sv_q, sv_n;
  logic [9:0]            sx_q, sx_n;
  logic [8:0]            sy_q, sy_n;
  logic                  patrol_en;
  logic                  expired;

  function automatic logic [KONG_CNT_W-1:0] phase_last(input kong_anim_t a);
    case (a)
      KONG_NORMAL: return KONG_CNT_W'(NORMAL_FRAMES - 1);
      KONG_GET:    return KONG_CNT_W'(GET_FRAMES - 1);
      KONG_HOLD:   return KONG_CNT_W'(HOLD_FRAMES - 1);
      default:     return KONG_CNT_W'(DROP_FRAMES - 1);
    endcase
  endfunction

  assign expired   = (cnt_q == phase_last(anim_q));
  assign patrol_en = (state_q == KONG_PLAYING) && (anim_q == KONG_NORMAL) &&
                     frame_tick && !game_over;

  kong_patrol #(
    .X_MIN  (X_MIN),
    .X_MAX  (X_MAX),
    .X_STEP (X_STEP),
    .HOME_X (HOME_X)
  ) u_patrol (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (game_over),
    .en    (patrol_en),
    .pos_x (posX)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= KONG_INITIAL;
      anim_q  <= KONG_NORMAL;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_n;
      anim_q  <= anim_n;
      cnt_q   <= cnt_n;
      sv_q    <= sv_n;
      sx_q    <= sx_n;
      sy_q    <= sy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    anim_n  = anim_q;
    cnt_n   = cnt_q;
    sv_n    = sv_q;
    sx_n    = sx_q;
    sy_n    = sy_q;
    if (game_over) begin
      state_n = KONG_INITIAL;
      anim_n  = KONG_NORMAL;
      cnt_n   = '0;
      sv_n    = 1'b0;
      sx_n    = '0;
      sy_n    = '0;
    end else begin
      case (state_q)
        KONG_INITIAL: begin
          if (start) begin
            state_n = KONG_PLAYING;
            anim_n  = KONG_NORMAL;
            cnt_n   = '0;
          end
        end
        default: begin
          if (sv_q && spawn_ready) sv_n = 1'b0;
          if (frame_tick) begin
            if (!expired) begin
              cnt_n = cnt_q + 1'b1;
            end else if (anim_q != KONG_DROP) begin
              anim_n = kong_next_anim(anim_q);
              cnt_n  = '0;
              // request is raised on the same edge DROP is entered
              if (kong_next_anim(anim_q) == KONG_DROP) begin
                sv_n = 1'b1;
                sx_n = posX;
                sy_n = 9'(HOME_Y + KONG_HEIGHT / 2);
              end
            end else if (!sv_q) begin
              anim_n = KONG_NORMAL;
              cnt_n  = '0;
            end
            // expired DROP with request still pending: counter holds saturated
          end
        end
      endcase
    end
  end

  assign state           = state_q;
  assign animation_state = anim_q;
  assign posY            = 9'(HOME_Y);
  assign spawn_valid     = sv_q;
  assign spawn_x         = sx_q;
  assign spawn_y         = sy_q;

endmodule

// File: tb/tb_kong_ctrl.sv
// tb/tb_kong_ctrl.sv - scoreboard bench for kong_ctrl throw cycle, patrol and spawn handshake
module tb_kong_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic       spawn_ready = 1'b1;

  logic       state, state2;
  logic [1:0] anim, anim2;
  logic [9:0] pos_x, pos_x2;
  logic [8:0] pos_y, pos_y2;
  logic       sv, sv2;
  logic [9:0] sx, sx2;
  logic [8:0] sy, sy2;

  int checks = 0;
  int errors = 0;
  int sv_cycles = 0;
  int sv_mark;
  logic       mon_en = 1'b0;
  logic [1:0] anim_prev = 2'b00;

  logic [1:0]  exp_anim_q[$];
  logic [18:0] exp_spawn_q[$];

  always #5 clk = ~clk;

  kong_ctrl #(
    .NORMAL_FRAMES(3), .GET_FRAMES(2), .HOLD_FRAMES(2), .DROP_FRAMES(1),
    .X_MIN(100), .X_MAX(540), .X_STEP(2), .HOME_X(320), .HOME_Y(80)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .game_over(game_over), .spawn_ready(spawn_ready), .state(state),
    .animation_state(anim), .posX(pos_x), .posY(pos_y), .spawn_valid(sv),
    .spawn_x(sx), .spawn_y(sy)
  );

  kong_ctrl #(
    .NORMAL_FRAMES(3), .GET_FRAMES(2), .HOLD_FRAMES(2), .DROP_FRAMES(1),
    .X_MIN(100), .X_MAX(540), .X_STEP(2), .HOME_X(537), .HOME_Y(80)
  ) dut_edge (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .game_over(game_over), .spawn_ready(spawn_ready), .state(state2),
    .animation_state(anim2), .posX(pos_x2), .posY(pos_y2), .spawn_valid(sv2),
    .spawn_x(sx2), .spawn_y(sy2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // animation_state monitor: every change must match the next expected phase
  always @(negedge clk) begin
    if (mon_en) begin
      if (anim != anim_prev) begin
        if (exp_anim_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL anim_unexpected: got %0d expected none", anim);
        end else begin
          chk("anim_seq", int'(anim), int'(exp_anim_q.pop_front()));
        end
      end
      anim_prev = anim;
    end
  end

  // spawn monitor: compare payload whenever a transfer will complete on the next edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (sv) sv_cycles++;
      if (sv && spawn_ready && !game_over) begin
        if (exp_spawn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spawn_unexpected: got x=%0d y=%0d expected none", sx, sy);
        end else begin
          chk("spawn_xy", int'({sx, sy}), int'(exp_spawn_q.pop_front()));
        end
      end
    end
  end

  task automatic do_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_anim"}, anim, 0);
    chk({tag, "_posx"}, pos_x, 320);
    chk({tag, "_posy"}, pos_y, 80);
    chk({tag, "_sv"}, sv, 0);
    chk({tag, "_sx"}, sx, 0);
    chk({tag, "_sy"}, sy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_reset_vals("reset");
    chk("reset_posx_edge", pos_x2, 537);
    mon_en = 1'b1;

    // full cycle, spawner always ready
    do_start();
    @(negedge clk);
    chk("start_state", state, 1);
    chk("start_anim", anim, 0);
    chk("start_posx", pos_x, 320);
    chk("start_sv", sv, 0);
    exp_anim_q.push_back(2'b01); exp_anim_q.push_back(2'b10);
    exp_anim_q.push_back(2'b11); exp_anim_q.push_back(2'b00);
    exp_spawn_q.push_back({10'd326, 9'd116});
    sv_mark = sv_cycles;
    do_tick(); @(negedge clk); chk("pat1_posx", pos_x, 322); chk("edge1_posx", pos_x2, 539);
    do_tick(); @(negedge clk); chk("pat2_posx", pos_x, 324); chk("edge2_posx", pos_x2, 540);
    do_tick(); @(negedge clk); chk("pat3_posx", pos_x, 326); chk("edge3_posx", pos_x2, 538);
    for (int i = 0; i < 5; i++) do_tick();
    @(negedge clk);
    chk("cyc1_anim_end", anim, 0);
    chk("cyc1_posx_frozen", pos_x, 326);
    chk("cyc1_sv_cycles", sv_cycles - sv_mark, 1);

    // spawner stalls for 5 ticks after DROP entry
    spawn_ready = 1'b0;
    exp_anim_q.push_back(2'b01); exp_anim_q.push_back(2'b10); exp_anim_q.push_back(2'b11);
    for (int i = 0; i < 7; i++) do_tick();
    for (int i = 0; i < 5; i++) begin
      do_tick();
      @(negedge clk);
      chk("stall_anim", anim, 3);
      chk("stall_sv", sv, 1);
      chk("stall_sx", sx, 332);
      chk("stall_sy", sy, 116);
    end
    exp_spawn_q.push_back({10'd332, 9'd116});
    exp_anim_q.push_back(2'b00);
    @(posedge clk); #1 spawn_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("release_sv", sv, 0);
    chk("release_anim", anim, 3);
    do_tick(); @(negedge clk);
    chk("release_next_anim", anim, 0);

    // game_over mid-DROP beats tick and ready in the same cycle
    spawn_ready = 1'b0;
    exp_anim_q.push_back(2'b01); exp_anim_q.push_back(2'b10);
    exp_anim_q.push_back(2'b11); exp_anim_q.push_back(2'b00);
    for (int i = 0; i < 7; i++) do_tick();
    @(negedge clk);
    chk("go_pre_sv", sv, 1);
    chk("go_pre_sx", sx, 338);
    @(posedge clk); #1 game_over = 1'b1; frame_tick = 1'b1; spawn_ready = 1'b1;
    @(posedge clk); #1 game_over = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0;
    chk_reset_vals("gameover");

    // reset while in HOLD, then restart from a clean NORMAL phase
    spawn_ready = 1'b1;
    do_start();
    exp_anim_q.push_back(2'b01); exp_anim_q.push_back(2'b10); exp_anim_q.push_back(2'b00);
    for (int i = 0; i < 5; i++) do_tick();
    @(negedge clk);
    chk("hold_anim", anim, 2);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk_reset_vals("rst_hold");
    do_start();
    exp_anim_q.push_back(2'b01);
    do_tick(); do_tick(); @(negedge clk);
    chk("restart_anim", anim, 0);
    chk("restart_posx", pos_x, 324);
    do_tick(); @(negedge clk);
    chk("restart_get", anim, 1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("anim_queue_empty", exp_anim_q.size(), 0);
    chk("spawn_queue_empty", exp_spawn_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kong_ctrl.md
Name: kong_ctrl

Overview:
- Game-logic driver for the Kong sprite.
- Produces the state, animation_state, posX and posY inputs consumed by the Kong renderer.
- Sequences the NORMAL->GET->HOLD->DROP throw cycle on VGA frame ticks and patrols Kong horizontally while in NORMAL.
- Issues a barrel-spawn request to the barrel spawner over a valid/ready handshake on every DROP.

Parameters:
- NORMAL_FRAMES, 90, frame ticks spent in NORMAL (>=1)
- GET_FRAMES, 20, frame ticks in GET (>=1)
- HOLD_FRAMES, 30, frame ticks in HOLD (>=1)
- DROP_FRAMES, 10, minimum frame ticks in DROP (>=1)
- X_MIN, 100, left patrol bound (sprite centre)
- X_MAX, 540, right patrol bound (sprite centre); X_MIN < X_MAX
- X_STEP, 2, pixels moved per frame tick in NORMAL
- HOME_X, 320, posX after reset/game over
- HOME_Y, 80, posY (constant)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per VGA frame
- start  in  1  level; begin play from INITIAL
- game_over  in  1  level; abort to INITIAL
- spawn_ready  in  1  barrel spawner can accept a request
- state  out  1  KONG_INITIAL=0 / KONG_PLAYING=1
- animation_state  out  2  NORMAL=00, GET=01, HOLD=10, DROP=11
- posX  out  10  sprite centre x
- posY  out  9  sprite centre y
- spawn_valid  out  1  barrel request pending
- spawn_x  out  10  barrel origin x
- spawn_y  out  9  barrel origin y

Behaviour:
- Clocking and reset: one clock, clk; rst_n is synchronous and active-low. All outputs are registered.
- Reset values: state=INITIAL, animation_state=NORMAL, posX=HOME_X, posY=HOME_Y, spawn_valid=0, spawn_x=0, spawn_y=0, frame counter=0, direction=right.
- INITIAL: outputs hold their reset values. If start=1 and game_over=0 at a clock edge, state=PLAYING on the next cycle, with animation_state=NORMAL and counter=0.
- PLAYING, counter: the counter increments only on frame_tick. When a tick arrives with counter==PHASE_FRAMES-1, the phase advances and the counter clears on that edge. Non-tick cycles change nothing in the counter.
- PLAYING, phase order: NORMAL->GET->HOLD->DROP->NORMAL.
- Patrol (NORMAL only, on frame_tick):
  - Moving right: if posX+X_STEP >= X_MAX, then posX=X_MAX and direction flips to left; else posX += X_STEP.
  - Moving left: mirror of the above using X_MIN.
  - Compute with 11-bit intermediates; no wrap-around.
  - posX is frozen in GET, HOLD and DROP.
- DROP entry, on the same edge animation_state becomes DROP:
  - spawn_valid=1.
  - spawn_x=posX.
  - spawn_y=posY+36 (half of KONG_HEIGHT).
- Handshake:
  - The transfer completes on an edge where spawn_valid & spawn_ready; spawn_valid clears on that edge.
  - spawn_x and spawn_y are stable while spawn_valid=1.
  - spawn_ready is a don't-care when spawn_valid=0.
  - Exactly one request per DROP.
- DROP exit: requires the counter to expire AND the handshake to be done. If the counter expires first, the counter saturates at DROP_FRAMES-1. The exit then happens on the first subsequent frame_tick after the handshake completes.
- game_over=1 (PLAYING or INITIAL):
  - Next cycle every output takes its reset value, direction resets and the counter clears.
  - A pending request is abandoned (spawn_valid=0).
  - game_over has priority over start, frame_tick and spawn_ready in the same cycle.
- start while PLAYING: ignored.
- posY always equals HOME_Y.

Decomposition:
- Shared package kong_pkg holds:
  - KONG_INITIAL and KONG_PLAYING.
  - KONG_NORMAL, KONG_GET, KONG_HOLD and KONG_DROP.
  - KONG_WIDTH=112 and KONG_HEIGHT=72.
  - The renderer imports the same package.
- One sub-module, kong_patrol, holds posX and the direction register with the bounce/clamp logic. It has an enable (NORMAL & frame_tick) and a synchronous clear.

Test Plan:
- Bench parameters: NORMAL_FRAMES=3, GET_FRAMES=2, HOLD_FRAMES=2, DROP_FRAMES=1, X_STEP=2.
- Reset, then start pulse -> state=1, animation_state=00 one cycle later; posX=320, spawn_valid=0.
- spawn_ready tied high, ticks every 10 cycles -> animation_state sequence 00(3 ticks),01(2),10(2),11(1),00. spawn_valid high exactly 1 cycle per cycle of the sequence, with spawn_x=326 and spawn_y=116.
- spawn_ready low for 5 ticks after DROP entry -> animation_state stays 11 and spawn_valid stays 1, with spawn_x/y unchanged. Raising spawn_ready clears spawn_valid after one edge; the next tick gives 00.
- HOME_X=537, X_MAX=540, NORMAL, 3 ticks -> posX 539, 540 (direction flips), 538.
- game_over asserted mid-DROP with spawn_valid=1 and a same-cycle frame_tick -> next cycle state=0, animation_state=00, posX=320, spawn_valid=0.
- rst_n low while PLAYING in HOLD -> all outputs return to their reset values on the next edge. A subsequent start restarts from NORMAL with counter=0.
